// File: rtl/turn_sequencer.sv
// Turn-flow controller: waits for a flip, holds the reveal window, then keeps the turn or pulses next_turn.
// Define TURN_SEQ_ACK_CHECK_EN to confirm that cur_turn moved after each advance pulse.
module turn_sequencer #(
    parameter int unsigned REVEAL_CYCLES = 50000000,
    parameter int unsigned ACK_TIMEOUT   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] N,
    input  logic [1:0] cur_turn,
    input  logic       game_start,
    input  logic       game_over,
    input  logic       flip_valid,
    input  logic       flip_match,
    output logic       next_turn,
    output logic       reveal,
    output logic [3:0] streak,
    output logic [7:0] turn_count,
    output logic       cfg_err,
    output logic       turn_err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_FLIP = 3'd1;
    localparam logic [2:0] S_REVEAL    = 3'd2;
    localparam logic [2:0] S_ADVANCE   = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd5;

    localparam logic [25:0] REVEAL_LOAD = 26'(REVEAL_CYCLES - 1);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [25:0] cnt;
    logic        match_q;
    logic        start_ok;
    logic        start_bad;
    logic        at_rest;

    assign start_ok  = game_start && (N != 2'b11);
    assign start_bad = game_start && (N == 2'b11);
    assign at_rest   = (state == S_IDLE) || (state == S_DONE);

`ifdef TURN_SEQ_ACK_CHECK_EN
    localparam logic [2:0] S_ACK_WAIT = 3'd4;
    localparam logic [3:0] ACK_LAST   = 4'(ACK_TIMEOUT - 1);

    logic [1:0] turn_q;
    logic [3:0] ack_cnt;
    logic       ack_seen;
    logic       ack_expired;

    assign ack_seen    = (cur_turn != turn_q);
    // ack_cnt is 1 in the first ACK_WAIT cycle, so turn_err lands ACK_TIMEOUT cycles after the pulse
    assign ack_expired = (state == S_ACK_WAIT) && !game_over && !ack_seen && (ack_cnt >= ACK_LAST);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_ok) state_nxt = S_WAIT_FLIP;
            end
            S_WAIT_FLIP: begin
                if (game_over)       state_nxt = S_DONE;
                else if (flip_valid) state_nxt = S_REVEAL;
            end
            S_REVEAL: begin
                if (game_over)       state_nxt = S_DONE;
                else if (cnt == '0)  state_nxt = match_q ? S_WAIT_FLIP : S_ADVANCE;
            end
`ifdef TURN_SEQ_ACK_CHECK_EN
            S_ADVANCE: state_nxt = S_ACK_WAIT;
            S_ACK_WAIT: begin
                if (game_over)                   state_nxt = S_DONE;
                else if (ack_seen || ack_expired) state_nxt = S_WAIT_FLIP;
            end
`else
            S_ADVANCE: state_nxt = S_WAIT_FLIP;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // reveal and next_turn are registered from the next state so both come straight from flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            match_q    <= 1'b0;
            reveal     <= 1'b0;
            next_turn  <= 1'b0;
            streak     <= '0;
            turn_count <= '0;
            cfg_err    <= 1'b0;
        end else begin
            state     <= state_nxt;
            reveal    <= (state_nxt == S_REVEAL);
            next_turn <= (state_nxt == S_ADVANCE);

            if (at_rest) begin
                if (start_ok) begin
                    cfg_err    <= 1'b0;
                    streak     <= '0;
                    turn_count <= '0;
                end else if (start_bad) begin
                    cfg_err <= 1'b1;
                end
            end

            if ((state == S_WAIT_FLIP) && (state_nxt == S_REVEAL)) begin
                match_q <= flip_match;
                cnt     <= REVEAL_LOAD;
            end else if ((state == S_REVEAL) && (cnt != '0)) begin
                cnt <= cnt - 26'd1;
            end

            if ((state == S_REVEAL) && (state_nxt == S_WAIT_FLIP) && (streak != 4'd15))
                streak <= streak + 4'd1;

            if (state_nxt == S_ADVANCE) begin
                streak     <= '0;
                turn_count <= turn_count + 8'd1;
            end
        end
    end

`ifdef TURN_SEQ_ACK_CHECK_EN
    // turn_q is captured on entry to ADVANCE so an immediate register response is still seen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            turn_q   <= '0;
            ack_cnt  <= '0;
            turn_err <= 1'b0;
        end else begin
            if (state_nxt == S_ADVANCE)
                turn_q <= cur_turn;

            if (state == S_ADVANCE)
                ack_cnt <= 4'd1;
            else if ((state == S_ACK_WAIT) && (ack_cnt != 4'hF))
                ack_cnt <= ack_cnt + 4'd1;

            if (at_rest && start_ok)
                turn_err <= 1'b0;
            else if (ack_expired)
                turn_err <= 1'b1;
        end
    end
`else
    localparam int unsigned UNUSED_ACK_TIMEOUT = ACK_TIMEOUT;
    logic unused_cur_turn;
    assign unused_cur_turn = ^cur_turn;
    assign turn_err        = 1'b0;
`endif

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: timestamp-based reference model plus directed and random stimulus.
// Expectations for turn_err follow TURN_SEQ_ACK_CHECK_EN.
module tb_turn_sequencer;

    localparam int RC = 4;
    localparam int AT = 4;
`ifdef TURN_SEQ_ACK_CHECK_EN
    localparam bit ACK_EN      = 1'b1;
    localparam int EXP_ERR_AT  = 5 + AT;
    localparam int EXP_ERR_HLD = 1;
`else
    localparam bit ACK_EN      = 1'b0;
    localparam int EXP_ERR_AT  = 0;
    localparam int EXP_ERR_HLD = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] N = 2'b00;
    logic [1:0] cur_turn = 2'b00;
    logic       game_start = 1'b0;
    logic       game_over = 1'b0;
    logic       flip_valid = 1'b0;
    logic       flip_match = 1'b0;
    logic       next_turn;
    logic       reveal;
    logic [3:0] streak;
    logic [7:0] turn_count;
    logic       cfg_err;
    logic       turn_err;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    bit cmp_on = 1'b0;
    bit reg_en = 1'b1;

    turn_sequencer #(.REVEAL_CYCLES(RC), .ACK_TIMEOUT(AT)) dut (
        .clk(clk), .rst_n(rst_n), .N(N), .cur_turn(cur_turn),
        .game_start(game_start), .game_over(game_over),
        .flip_valid(flip_valid), .flip_match(flip_match),
        .next_turn(next_turn), .reveal(reveal), .streak(streak),
        .turn_count(turn_count), .cfg_err(cfg_err), .turn_err(turn_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Turn register: advances modulo the player count on each next_turn pulse
    initial forever begin
        @(posedge clk);
        if (reg_en && next_turn)
            cur_turn <= 2'((int'(cur_turn) + 1) % ((N == 2'b00) ? 2 : (N == 2'b01) ? 3 : 4));
    end

    // Reference model: game flow expressed as timestamps of the flip, the pulse and the ack window
    int cyc = 0;
    bit m_in_game = 0;
    int m_flip_t = -1000;
    bit m_flip_m = 0;
    int m_pulse_t = -1000;
    bit m_ack_open = 0;
    int m_ref = 0;
    int m_count = 0;
    int m_streak = 0;
    bit m_cfg = 0;
    bit m_err = 0;
    bit e_reveal = 0;
    bit e_next = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_in_game = 0; m_flip_t = -1000; m_pulse_t = -1000; m_ack_open = 0;
            m_count = 0; m_streak = 0; m_cfg = 0; m_err = 0; e_reveal = 0; e_next = 0;
        end else begin
            int t;
            t = cyc;
            if (!m_in_game) begin
                if (game_start) begin
                    if (N != 2'b11) begin
                        m_in_game = 1; m_streak = 0; m_count = 0; m_err = 0; m_cfg = 0;
                        m_flip_t = -1000; m_pulse_t = -1000; m_ack_open = 0;
                    end else begin
                        m_cfg = 1;
                    end
                end
            end else if (t > m_flip_t && t <= m_flip_t + RC) begin
                if (game_over) begin
                    m_in_game = 0; m_flip_t = -1000;
                end else if (t == m_flip_t + RC) begin
                    if (m_flip_m) begin
                        if (m_streak < 15) m_streak++;
                    end else begin
                        m_pulse_t = t + 1; m_streak = 0; m_count = (m_count + 1) % 256;
                        m_ref = int'(cur_turn);
                    end
                end
            end else if (t == m_pulse_t) begin
                m_ack_open = ACK_EN;
            end else if (m_ack_open) begin
                if (game_over) begin
                    m_in_game = 0; m_ack_open = 0;
                end else if (int'(cur_turn) != m_ref) begin
                    m_ack_open = 0;
                end else if (t - m_pulse_t >= AT - 1) begin
                    m_err = 1; m_ack_open = 0;
                end
            end else begin
                if (game_over) m_in_game = 0;
                else if (flip_valid) begin
                    m_flip_t = t; m_flip_m = flip_match;
                end
            end
            e_reveal = m_in_game && (t + 1 > m_flip_t) && (t + 1 <= m_flip_t + RC);
            e_next   = m_in_game && (m_pulse_t == t + 1);
            cyc++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (next_turn) pulses++;
        if (cmp_on) begin
            chk("reveal", int'(reveal), int'(e_reveal));
            chk("next_turn", int'(next_turn), int'(e_next));
            chk("streak", int'(streak), m_streak);
            chk("turn_count", int'(turn_count), m_count);
            chk("cfg_err", int'(cfg_err), int'(m_cfg));
            chk("turn_err", int'(turn_err), int'(m_err) & int'(ACK_EN));
        end
    end

    task automatic start_game(input logic [1:0] n);
        N = n; game_start = 1'b1;
        @(negedge clk);
        game_start = 1'b0;
    endtask

    task automatic flip(input logic m);
        flip_valid = 1'b1; flip_match = m;
        @(negedge clk);
        flip_valid = 1'b0;
    endtask

    task automatic end_game();
        game_over = 1'b1;
        @(negedge clk);
        game_over = 1'b0;
    endtask

    // Observe 12 cycles starting one cycle after the flip cycle
    task automatic miss_window(output int rev_n, output int nt_n, output int nt_at, output int err_at);
        rev_n = 0; nt_n = 0; nt_at = 0; err_at = 0;
        for (int i = 1; i <= 12; i++) begin
            if (reveal) rev_n++;
            if (next_turn) begin nt_n++; nt_at = i; end
            if (turn_err && err_at == 0) err_at = i;
            @(negedge clk);
        end
    endtask

    initial begin
        int rev_n, nt_n, nt_at, err_at, p0, waited;
        repeat (3) @(negedge clk);
        cmp_on = 1'b1;
        chk("rst_next_turn", int'(next_turn), 0);
        chk("rst_reveal", int'(reveal), 0);
        chk("rst_streak", int'(streak), 0);
        chk("rst_turn_count", int'(turn_count), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_turn_err", int'(turn_err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Invalid player count blocks the start
        start_game(2'b11);
        chk("inv_cfg_err", int'(cfg_err), 1);
        flip(1'b0);
        chk("inv_no_reveal", int'(reveal), 0);
        start_game(2'b00);
        chk("valid_cfg_clear", int'(cfg_err), 0);
        N = 2'b01;

        // Single miss
        flip(1'b0);
        miss_window(rev_n, nt_n, nt_at, err_at);
        chk("miss_reveal_len", rev_n, 4);
        chk("miss_pulse_at", nt_at, 5);
        chk("miss_pulse_n", nt_n, 1);
        chk("miss_turn_count", int'(turn_count), 1);
        chk("miss_turn_err", int'(turn_err), 0);
        chk("model_count", m_count, 1);

        // Match streak then miss
        for (int s = 1; s <= 3; s++) begin
            flip(1'b1);
            repeat (6) @(negedge clk);
            chk("streak_step", int'(streak), s);
        end
        p0 = pulses;
        flip(1'b0);
        miss_window(rev_n, nt_n, nt_at, err_at);
        chk("streak_cleared", int'(streak), 0);
        chk("streak_pulses", pulses - p0, 1);
        chk("streak_turn_count", int'(turn_count), 2);

        // Abort during reveal
        flip(1'b1);
        @(negedge clk);
        chk("abort_in_reveal", int'(reveal), 1);
        p0 = pulses;
        end_game();
        chk("abort_reveal_low", int'(reveal), 0);
        repeat (8) @(negedge clk);
        chk("abort_no_pulse", pulses - p0, 0);
        start_game(2'b01);
        chk("restart_count", int'(turn_count), 0);
        chk("restart_streak", int'(streak), 0);
        flip(1'b0);
        chk("restart_reveal", int'(reveal), 1);
        repeat (12) @(negedge clk);

        // Unacknowledged advance
        reg_en = 1'b0;
        flip(1'b0);
        miss_window(rev_n, nt_n, nt_at, err_at);
        chk("ack_timeout_at", err_at, EXP_ERR_AT);
        reg_en = 1'b1;
        flip(1'b0);
        miss_window(rev_n, nt_n, nt_at, err_at);
        chk("ack_err_sticky", int'(turn_err), EXP_ERR_HLD);
        end_game();
        start_game(2'b10);
        chk("ack_err_cleared", int'(turn_err), 0);

        // Randomized play
        for (int i = 0; i < 2000; i++) begin
            flip_valid = ($urandom_range(3) == 0);
            flip_match = 1'($urandom_range(1));
            game_over  = ($urandom_range(59) == 0);
            game_start = ($urandom_range(39) == 0);
            if ($urandom_range(15) == 0) N = 2'($urandom_range(3));
            reg_en = ($urandom_range(7) != 0);
            @(negedge clk);
        end
        flip_valid = 1'b0; game_over = 1'b0; game_start = 1'b0; reg_en = 1'b1;

        // Reset in the middle of the advance pulse
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_game(2'b01);
        flip(1'b0);
        waited = 0;
        while (!next_turn && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("rst_pulse_found", int'(next_turn), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_next_turn", int'(next_turn), 0);
        chk("async_reveal", int'(reveal), 0);
        chk("async_turn_count", int'(turn_count), 0);
        chk("async_streak", int'(streak), 0);
        chk("async_cfg_err", int'(cfg_err), 0);
        chk("async_turn_err", int'(turn_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_count", int'(turn_count), 0);
        flip(1'b0);
        chk("post_rst_idle", int'(reveal), 0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
